// File: rtl/phy_rx_dpll_if.sv
// Receive-side bundle of the oversampling DPLL: line inputs plus recovered-bit outputs.
// The master drives the line, the slave is the DPLL.
interface phy_rx_dpll_if #(
  parameter int unsigned OSR = 4
);
  localparam int unsigned CW = $clog2(OSR);

  logic          r_dat;
  logic          r_se_en;
  logic          rr_dat;
  logic          rr_dat_en;
  logic          rr_se_en;
  logic          rx_active;
  logic          rx_err;
  logic [CW-1:0] phase;

  modport master (
    output r_dat, r_se_en,
    input  rr_dat, rr_dat_en, rr_se_en, rx_active, rx_err, phase
  );

  modport slave (
    input  r_dat, r_se_en,
    output rr_dat, rr_dat_en, rr_se_en, rx_active, rx_err, phase
  );
endinterface

// File: rtl/phy_rx_dpll.sv
// Oversampling receive DPLL: re-aligns a bit-phase counter on every data edge, strobes
// mid-bit, and tracks packet / EOP framing with a bit-stuffing run-length check.
module phy_rx_dpll #(
  parameter int unsigned OSR     = 4,
  parameter int unsigned MAX_RUN = 7
) (
  input logic          clk,
  input logic          rst_n,
  phy_rx_dpll_if.slave rx
);
  localparam int unsigned   CW       = $clog2(OSR);
  localparam int unsigned   HALF     = OSR / 2;
  localparam logic [CW-1:0] PhHalf   = CW'(HALF);
  localparam logic [4:0]    RunLimit = 5'(MAX_RUN);

  typedef enum logic [1:0] {StIdle, StActive, StEop} state_e;

  state_e        state_q, state_d;
  logic          d_q, se_q;
  logic [CW-1:0] ph_q, ph_d;
  logic [3:0]    run_q, run_d;
  logic [4:0]    run_inc;
  logic          rr_dat_q, rr_dat_d;
  logic          rr_dat_en_q, rr_dat_en_d;
  logic          rr_se_en_q, rr_se_en_d;
  logic          rx_err_q, rx_err_d;
  logic          edge_det;
  logic          strobe;

  // Transitions into or out of SE0 are not data edges.
  assign edge_det = ~rx.r_se_en & ~se_q & (rx.r_dat != d_q);
  assign strobe   = (ph_q == PhHalf) & ~edge_det & (state_q != StIdle);
  assign ph_d     = edge_det ? CW'(1) : ph_q + CW'(1);
  assign run_inc  = {1'b0, run_q} + 5'd1;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    rr_dat_d    = rr_dat_q;
    rr_dat_en_d = 1'b0;
    rr_se_en_d  = 1'b0;
    rx_err_d    = 1'b0;

    if (edge_det) begin
      run_d = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (edge_det && !rx.r_dat) begin
          state_d = StActive;
        end
      end
      StActive: begin
        if (strobe) begin
          if (rx.r_se_en) begin
            rr_se_en_d  = 1'b1;
            rr_dat_d    = 1'b1;
            rr_dat_en_d = 1'b1;
            state_d     = StEop;
          end else if (run_inc > RunLimit) begin
            rx_err_d = 1'b1;
            state_d  = StIdle;
          end else begin
            rr_dat_d    = rx.r_dat;
            rr_dat_en_d = 1'b1;
            run_d       = run_inc[3:0];
          end
        end
      end
      StEop: begin
        // SE0 of any length keeps us here; J closes cleanly, K is a bad EOP.
        if (strobe && !rx.r_se_en) begin
          state_d  = StIdle;
          rx_err_d = ~rx.r_dat;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      d_q         <= 1'b1;
      se_q        <= 1'b0;
      ph_q        <= '0;
      run_q       <= '0;
      rr_dat_q    <= 1'b1;
      rr_dat_en_q <= 1'b0;
      rr_se_en_q  <= 1'b0;
      rx_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      d_q         <= rx.r_dat;
      se_q        <= rx.r_se_en;
      ph_q        <= ph_d;
      run_q       <= run_d;
      rr_dat_q    <= rr_dat_d;
      rr_dat_en_q <= rr_dat_en_d;
      rr_se_en_q  <= rr_se_en_d;
      rx_err_q    <= rx_err_d;
    end
  end

  assign rx.rr_dat    = rr_dat_q;
  assign rx.rr_dat_en = rr_dat_en_q;
  assign rx.rr_se_en  = rr_se_en_q;
  assign rx.rx_err    = rx_err_q;
  assign rx.rx_active = (state_q != StIdle);
  assign rx.phase     = ph_q;
endmodule

// File: tb/tb_phy_rx_dpll.sv
// Bench for phy_rx_dpll: a cycle table for OSR=4, directed corner sequences and random
// packets whose recovered bit stream is compared against the transmitted levels.
module tb_phy_rx_dpll;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  phy_rx_dpll_if #(.OSR(4)) if4 ();
  phy_rx_dpll_if #(.OSR(8)) if8 ();

  phy_rx_dpll #(.OSR(4), .MAX_RUN(7)) u4 (.clk(clk), .rst_n(rst_n), .rx(if4));
  phy_rx_dpll #(.OSR(8), .MAX_RUN(7)) u8 (.clk(clk), .rst_n(rst_n), .rx(if8));

  int nvec = 0, nerr = 0;
  int sel = 0, osr = 4, half = 2;
  int cyc = 0, last_edge = 0, err_cyc = -1, fall_cyc = -1, cnt_se = 0, cnt_err = 0;
  bit drv_dat = 1'b1, drv_se = 1'b0, prev_dat = 1'b1, prev_se = 1'b0, prev_act = 1'b0;
  bit chk_align = 1'b0, err_en = 1'b0;
  bit got_q[$];

  // Unselected DUT sees an idle J line.
  assign if4.r_dat   = (sel == 0) ? drv_dat : 1'b1;
  assign if4.r_se_en = (sel == 0) ? drv_se : 1'b0;
  assign if8.r_dat   = (sel == 1) ? drv_dat : 1'b1;
  assign if8.r_se_en = (sel == 1) ? drv_se : 1'b0;

  logic o_dat, o_en, o_se, o_act, o_err;
  assign o_dat = (sel == 0) ? if4.rr_dat    : if8.rr_dat;
  assign o_en  = (sel == 0) ? if4.rr_dat_en : if8.rr_dat_en;
  assign o_se  = (sel == 0) ? if4.rr_se_en  : if8.rr_se_en;
  assign o_act = (sel == 0) ? if4.rx_active : if8.rx_active;
  assign o_err = (sel == 0) ? if4.rx_err    : if8.rx_err;

  typedef struct {
    bit dat; bit se;
    bit e_dat; bit e_en; bit e_se; bit e_act; bit e_err; int e_ph;
  } vec_t;
  vec_t tbl[23];

  task automatic check(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: inputs already applied, outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (!drv_se && !prev_se && drv_dat != prev_dat) last_edge = cyc;
    prev_dat = drv_dat;
    prev_se  = drv_se;
    if (o_en && !o_se) begin
      got_q.push_back(o_dat);
      if (chk_align) check("strobe_align", cyc - last_edge, half);
    end
    if (o_se) begin
      cnt_se++;
      check("se_pulse_dat", o_dat, 1);
      check("se_pulse_en", o_en, 1);
    end
    if (o_err) begin
      cnt_err++;
      err_cyc = cyc;
      err_en  = o_en;
    end
    if (prev_act && !o_act) fall_cyc = cyc;
    prev_act = o_act;
  endtask

  task automatic drive(input bit d, input bit s, input int n);
    drv_dat = d;
    drv_se  = s;
    repeat (n) step();
  endtask

  task automatic clear_mon();
    got_q.delete();
    cnt_se    = 0;
    cnt_err   = 0;
    err_cyc   = -1;
    fall_cyc  = -1;
    chk_align = 1'b0;
  endtask

  task automatic do_reset(input int s);
    sel     = s;
    osr     = (s == 0) ? 4 : 8;
    half    = osr / 2;
    drv_dat = 1'b1;
    drv_se  = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    prev_dat = 1'b1;
    prev_se  = 1'b0;
    prev_act = 1'b0;
    clear_mon();
  endtask

  // Bit levels starting with the SOP K; runs capped at 7 unless every bit must toggle.
  task automatic make_levels(input int n, input bit alt, output bit lv[$]);
    int run;
    bit last, nb;
    lv.delete();
    lv.push_back(1'b0);
    run = 1;
    for (int i = 1; i < n; i++) begin
      last = lv[lv.size()-1];
      if (alt || run >= 7) nb = ~last;
      else nb = ($urandom_range(0, 2) == 0) ? ~last : last;
      run = (nb == last) ? run + 1 : 1;
      lv.push_back(nb);
    end
  endtask

  task automatic send_packet(input bit lv[$], input int period, input int se0_bits,
                             input bit end_k);
    int j0;
    drive(1'b1, 1'b0, 3 * osr);
    clear_mon();
    chk_align = (period != osr);
    foreach (lv[i]) drive(lv[i], 1'b0, period);
    drive(1'b0, 1'b1, se0_bits * period);
    chk_align = 1'b0;
    j0 = cyc + 1;
    drive(end_k ? 1'b0 : 1'b1, 1'b0, period);
    drive(1'b1, 1'b0, 2 * osr);
    check("pkt_len", got_q.size(), lv.size());
    foreach (lv[i]) if (i < got_q.size()) check("pkt_bit", got_q[i], lv[i]);
    check("pkt_se_cnt", cnt_se, 1);
    check("pkt_err_cnt", cnt_err, end_k);
    check("pkt_active_end", o_act, 0);
    if (period == osr) check("pkt_fall_cyc", fall_cyc, j0 + half);
  endtask

  initial begin
    bit lv[$];
    int sop, ones, k, p;

    // dat se | rr_dat en se act err phase
    tbl[0]  = '{1, 0, 1, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, 0, 1, 0, 0, 0, 0, 2};
    tbl[2]  = '{1, 0, 1, 0, 0, 0, 0, 3};
    tbl[3]  = '{0, 0, 1, 0, 0, 1, 0, 1};
    tbl[4]  = '{0, 0, 1, 0, 0, 1, 0, 2};
    tbl[5]  = '{0, 0, 0, 1, 0, 1, 0, 3};
    tbl[6]  = '{0, 0, 0, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 1, 0, 1};
    tbl[8]  = '{0, 0, 0, 0, 0, 1, 0, 2};
    tbl[9]  = '{0, 0, 0, 1, 0, 1, 0, 3};
    tbl[10] = '{0, 0, 0, 0, 0, 1, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 0, 1, 0, 1};
    tbl[12] = '{1, 0, 0, 0, 0, 1, 0, 2};
    tbl[13] = '{1, 0, 1, 1, 0, 1, 0, 3};
    tbl[14] = '{1, 0, 1, 0, 0, 1, 0, 0};
    tbl[15] = '{0, 1, 1, 0, 0, 1, 0, 1};
    tbl[16] = '{0, 1, 1, 0, 0, 1, 0, 2};
    tbl[17] = '{0, 1, 1, 1, 1, 1, 0, 3};
    tbl[18] = '{0, 1, 1, 0, 0, 1, 0, 0};
    tbl[19] = '{1, 0, 1, 0, 0, 1, 0, 1};
    tbl[20] = '{1, 0, 1, 0, 0, 1, 0, 2};
    tbl[21] = '{1, 0, 1, 0, 0, 0, 0, 3};
    tbl[22] = '{1, 0, 1, 0, 0, 0, 0, 0};

    do_reset(0);
    check("rst_rr_dat", o_dat, 1);
    check("rst_en", o_en, 0);
    check("rst_se", o_se, 0);
    check("rst_active", o_act, 0);
    check("rst_err", o_err, 0);
    check("rst_phase", if4.phase, 0);

    foreach (tbl[i]) begin
      drv_dat = tbl[i].dat;
      drv_se  = tbl[i].se;
      step();
      check($sformatf("tbl%0d_rr_dat", i), if4.rr_dat, tbl[i].e_dat);
      check($sformatf("tbl%0d_en", i), if4.rr_dat_en, tbl[i].e_en);
      check($sformatf("tbl%0d_se", i), if4.rr_se_en, tbl[i].e_se);
      check($sformatf("tbl%0d_active", i), if4.rx_active, tbl[i].e_act);
      check($sformatf("tbl%0d_err", i), if4.rx_err, tbl[i].e_err);
      check($sformatf("tbl%0d_phase", i), if4.phase, tbl[i].e_ph);
    end

    // Eight edgeless bits: seven strobes, then the eighth is a run violation.
    do_reset(0);
    drive(1'b1, 1'b0, 12);
    clear_mon();
    sop = cyc + 1;
    drive(1'b0, 1'b0, 8 * osr);
    ones = 0;
    foreach (got_q[i]) ones += got_q[i];
    check("run_bits", got_q.size(), 7);
    check("run_ones", ones, 0);
    check("run_err_cnt", cnt_err, 1);
    check("run_err_cyc", err_cyc, sop + half + 7 * osr);
    check("run_err_no_en", err_en, 0);
    check("run_active", o_act, 0);
    drive(1'b0, 1'b1, 2 * osr);
    drive(1'b1, 1'b0, 2 * osr);
    check("run_idle_se", cnt_se, 0);

    // Exactly MAX_RUN edgeless bits is legal.
    lv.delete();
    repeat (7) lv.push_back(1'b0);
    send_packet(lv, 4, 2, 1'b0);

    // SE0 followed by K is a bad EOP.
    make_levels(6, 1'b0, lv);
    send_packet(lv, 4, 1, 1'b1);

    // Slow sender, toggling every bit.
    make_levels(64, 1'b1, lv);
    send_packet(lv, 5, 2, 1'b0);

    // Reset mid-packet while a strobe pulse is showing.
    do_reset(0);
    drive(1'b1, 1'b0, 12);
    drv_dat = 1'b0;
    k = 0;
    while (!o_en && k < 20) begin
      step();
      k++;
    end
    check("abort_strobe_seen", o_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_rr_dat", o_dat, 1);
    check("abort_en", o_en, 0);
    check("abort_se", o_se, 0);
    check("abort_active", o_act, 0);
    check("abort_err", o_err, 0);
    check("abort_phase", if4.phase, 0);
    drv_dat = 1'b1;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    prev_dat = 1'b1;
    prev_se  = 1'b0;
    prev_act = 1'b0;
    clear_mon();
    drive(1'b1, 1'b0, 12);
    check("abort_idle_bits", got_q.size(), 0);
    check("abort_idle_active", o_act, 0);
    make_levels(10, 1'b0, lv);
    send_packet(lv, 4, 2, 1'b0);

    // Random packets at OSR=4: nominal rate with free runs, or off-rate toggling.
    for (int n = 0; n < 10; n++) begin
      p = $urandom_range(0, 2);
      if (p == 0) begin
        make_levels($urandom_range(4, 24), 1'b0, lv);
        send_packet(lv, 4, 2, 1'b0);
      end else begin
        make_levels($urandom_range(4, 24), 1'b1, lv);
        send_packet(lv, (p == 1) ? 3 : 5, 2, 1'b0);
      end
    end

    // OSR=8: packet, two bit times of SE0, then J.
    do_reset(1);
    for (int n = 0; n < 3; n++) begin
      make_levels($urandom_range(4, 16), 1'b0, lv);
      send_packet(lv, 8, 2, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
